// File: rtl/uart_tx_frame_if.sv
// ----------------------------------------------------------------------------
// uart_tx_frame_if
// Handshake bundle between the tx_start generator / receive data register
// and the UART transmitter.
//
//   tx_start  request strobe (only its rising edge matters to the transmitter)
//   tx_data   byte to send, sampled when the request is accepted
//   txd       serial line, idle high
//   tx_busy   frame in progress
//   tx_done   one-cycle pulse after the last stop bit
//
// Modports:
//   master  - the requester: drives tx_start/tx_data, observes line status
//   slave   - the transmitter: consumes the request, drives line status
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

interface uart_tx_frame_if #(
    parameter int DATA_BITS = 8
);
    logic                 tx_start;
    logic [DATA_BITS-1:0] tx_data;
    logic                 txd;
    logic                 tx_busy;
    logic                 tx_done;

    modport master (
        output tx_start,
        output tx_data,
        input  txd,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output txd,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/uart_tx_frame.sv
// ----------------------------------------------------------------------------
// uart_tx_frame
// UART transmitter for the echo/loopback path. Each rising edge of tx_start
// seen while idle sends one frame: start bit, DATA_BITS payload bits LSB
// first, optional parity bit, STOP_BITS stop bits. The bit rate comes from an
// internal divider (DIV = CLK_FREQ/BAUD clk cycles per bit), so everything
// runs on clk.
//
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit after the
// payload (even parity when PARITY_ODD=0, odd when PARITY_ODD=1). Without the
// macro there is no parity state or logic and PARITY_ODD has no effect.
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-low reset
//   bus    uart_tx_frame_if.slave: tx_start, tx_data in; txd, tx_busy,
//          tx_done out (all outputs registered)
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_tx_frame #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic          clk,
    input  logic          reset,
    uart_tx_frame_if.slave bus
);
    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W = 3;

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    // Parameter legality markers: an out-of-range setting leaves a clearly
    // named block in the elaborated hierarchy.
    if (DIV < 2) begin : g_bad_div_below_2
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity_odd
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_DONE
    } state_t;

    state_t               state_reg,    state_next;
    logic [CNT_W-1:0]     baud_cnt_reg, baud_cnt_next;
    logic [BIT_W-1:0]     bit_cnt_reg,  bit_cnt_next;
    logic [DATA_BITS-1:0] shift_reg,    shift_next;
    logic                 start_d_reg;
    logic                 txd_reg,      txd_next;
    logic                 tx_busy_reg,  tx_busy_next;
    logic                 tx_done_reg,  tx_done_next;
`ifdef UART_TX_PARITY_EN
    logic                 parity_reg,   parity_next;
`endif

    logic start_rise;
    logic bit_end;

    // A level-held request yields a single rising edge, hence a single frame.
    assign start_rise = bus.tx_start & ~start_d_reg;
    assign bit_end    = (baud_cnt_reg == BAUD_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= S_IDLE;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            start_d_reg  <= 1'b0;
            txd_reg      <= 1'b1;
            tx_busy_reg  <= 1'b0;
            tx_done_reg  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_reg   <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            baud_cnt_reg <= baud_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            start_d_reg  <= bus.tx_start;
            txd_reg      <= txd_next;
            tx_busy_reg  <= tx_busy_next;
            tx_done_reg  <= tx_done_next;
`ifdef UART_TX_PARITY_EN
            parity_reg   <= parity_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
`ifdef UART_TX_PARITY_EN
        parity_next   = parity_reg;
`endif
        // Inside a bit-carrying state the divider free-runs and wraps at
        // DIV-1; IDLE and DONE override this and hold it at zero.
        baud_cnt_next = bit_end ? '0 : baud_cnt_reg + CNT_W'(1);

        case (state_reg)
            S_IDLE: begin
                baud_cnt_next = '0;
                bit_cnt_next  = '0;
                if (start_rise) begin
                    state_next = S_START;
                    shift_next = bus.tx_data;
`ifdef UART_TX_PARITY_EN
                    parity_next = (^bus.tx_data) ^ 1'(PARITY_ODD);
`endif
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_next   = S_DATA;
                    bit_cnt_next = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_next = shift_reg >> 1;
                    if (bit_cnt_reg == DATA_LAST) begin
                        bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
                        state_next   = S_PARITY;
`else
                        state_next   = S_STOP;
`endif
                    end else begin
                        bit_cnt_next = bit_cnt_reg + BIT_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_next   = S_STOP;
                    bit_cnt_next = '0;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    if (bit_cnt_reg == STOP_LAST) begin
                        state_next   = S_DONE;
                        bit_cnt_next = '0;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + BIT_W'(1);
                    end
                end
            end
            S_DONE: begin
                // A request arriving here is dropped: only IDLE accepts.
                state_next    = S_IDLE;
                baud_cnt_next = '0;
                bit_cnt_next  = '0;
            end
            default: begin
                state_next    = S_IDLE;
                baud_cnt_next = '0;
                bit_cnt_next  = '0;
            end
        endcase

        // Outputs are decoded from the next state so they can be registered
        // and still line up with the state they describe.
        txd_next     = 1'b1;
        tx_busy_next = 1'b0;
        tx_done_next = 1'b0;
        case (state_next)
            S_START: begin
                txd_next     = 1'b0;
                tx_busy_next = 1'b1;
            end
            S_DATA: begin
                txd_next     = shift_next[0];
                tx_busy_next = 1'b1;
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                txd_next     = parity_next;
                tx_busy_next = 1'b1;
            end
`endif
            S_STOP: begin
                tx_busy_next = 1'b1;
            end
            S_DONE: begin
                tx_done_next = 1'b1;
            end
            default: begin
                txd_next = 1'b1;
            end
        endcase
    end

    assign bus.txd     = txd_reg;
    assign bus.tx_busy = tx_busy_reg;
    assign bus.tx_done = tx_done_reg;

endmodule

// File: tb/tb_uart_tx_frame.sv
`timescale 1ns/1ps

module tb_uart_tx_frame;
    localparam int DIV0 = 434;  // 50 MHz / 115200
    localparam int DIV1 = 4;    // 400 Hz / 100
`ifdef UART_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int DONE_AT0 = (1 + 8 + PAR_BITS + 1) * DIV0 + 1;
    localparam int DONE_AT1 = (1 + 8 + PAR_BITS + 2) * DIV1 + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         dut;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];

    uart_tx_frame_if #(.DATA_BITS(8)) bus0 ();
    uart_tx_frame_if #(.DATA_BITS(8)) bus1 ();

    uart_tx_frame #(
        .CLK_FREQ(50000000), .BAUD(115200), .DATA_BITS(8),
        .STOP_BITS(1), .PARITY_ODD(1)
    ) u_dut0 (
        .clk(clk), .reset(rst_n), .bus(bus0)
    );

    uart_tx_frame #(
        .CLK_FREQ(400), .BAUD(100), .DATA_BITS(8),
        .STOP_BITS(2), .PARITY_ODD(0)
    ) u_dut1 (
        .clk(clk), .reset(rst_n), .bus(bus1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Per-DUT line monitor: pops the expected byte when a start bit appears,
    // then checks txd every cycle against the ideal frame, tx_busy through
    // the frame, and the exact tx_done cycle.
    for (genvar gi = 0; gi < 2; gi++) begin : g_mon
        localparam int   DIVM  = (gi == 0) ? DIV0 : DIV1;
        localparam int   NSTOP = (gi == 0) ? 1 : 2;
        localparam int   NBITS = 1 + 8 + PAR_BITS + NSTOP;
        localparam int   LAST  = NBITS * DIVM;
        localparam logic PODD  = (gi == 0);

        logic m_txd, m_busy, m_done;
        int   done_cnt     = 0;
        int   last_done_at = 0;

        if (gi == 0) begin : g_sel0
            assign m_txd  = bus0.txd;
            assign m_busy = bus0.tx_busy;
            assign m_done = bus0.tx_done;
        end else begin : g_sel1
            assign m_txd  = bus1.txd;
            assign m_busy = bus1.tx_busy;
            assign m_done = bus1.tx_done;
        end

        initial begin : mon
            logic [NBITS-1:0] exp_bits;
            int   cnt;
            bit   active;
            int   bad_bits;
            int   bad_busy;
            exp_t e;
            active = 1'b0;
            cnt = 0; bad_bits = 0; bad_busy = 0;
            exp_bits = '1;
            forever begin
                @(negedge clk);
                if (m_done === 1'b1) done_cnt++;
                if (rst_n !== 1'b1) begin
                    active = 1'b0;
                end else begin
                    if (active) begin
                        cnt++;
                        if (cnt == LAST + 1) begin
                            check($sformatf("dut%0d_done_on_time", gi), m_done, 1);
                            check($sformatf("dut%0d_txd_bits", gi), bad_bits, 0);
                            check($sformatf("dut%0d_busy_in_frame", gi), bad_busy, 0);
                            check($sformatf("dut%0d_busy_in_done", gi), m_busy, 0);
                            check($sformatf("dut%0d_txd_in_done", gi), m_txd, 1);
                            if (m_done === 1'b1) last_done_at = cnt;
                            $display("dut%0d frame 0x%02h done at cycle %0d", gi, e.data, cnt);
                            active = 1'b0;
                        end else if (m_done === 1'b1) begin
                            check($sformatf("dut%0d_done_at", gi), cnt, LAST + 1);
                            active = 1'b0;
                        end
                    end else begin
                        if (m_done === 1'b1)
                            check($sformatf("dut%0d_done_without_frame", gi), 1, 0);
                        if (m_txd === 1'b0) begin
                            if (exp_q.size() == 0) begin
                                check($sformatf("dut%0d_unexpected_frame", gi), 1, 0);
                                e.dut = gi;
                                e.data = 8'h00;
                            end else begin
                                e = exp_q.pop_front();
                                check($sformatf("dut%0d_frame_owner", gi), e.dut, gi);
                            end
                            exp_bits = '1;
                            exp_bits[0] = 1'b0;
                            for (int i = 0; i < 8; i++) exp_bits[1 + i] = e.data[i];
`ifdef UART_TX_PARITY_EN
                            exp_bits[9] = (^e.data) ^ PODD;
`endif
                            active = 1'b1;
                            cnt = 1;
                            bad_bits = 0;
                            bad_busy = 0;
                        end
                    end
                    if (active && cnt <= LAST) begin
                        if (m_txd !== exp_bits[(cnt - 1) / DIVM]) bad_bits++;
                        if (m_busy !== 1'b1) bad_busy++;
                    end
                end
            end
        end
    end

    function automatic int done_count(input int d);
        return (d == 0) ? g_mon[0].done_cnt : g_mon[1].done_cnt;
    endfunction

    task automatic drive(input int d, input logic s, input logic [7:0] v);
        if (d == 0) begin
            bus0.tx_start = s;
            bus0.tx_data  = v;
        end else begin
            bus1.tx_start = s;
            bus1.tx_data  = v;
        end
    endtask

    // Raise tx_start for 'hold' cycles; tx_data is scrambled right after the
    // accepting edge so a late data change would corrupt the frame.
    task automatic send(input int d, input logic [7:0] data, input int hold);
        @(posedge clk); #1;
        drive(d, 1'b1, data);
        exp_q.push_back('{dut: d, data: data});
        @(posedge clk); #1;
        drive(d, 1'b1, ~data);
        for (int i = 1; i < hold; i++) begin
            @(posedge clk); #1;
        end
        drive(d, 1'b0, ~data);
    endtask

    task automatic wait_done(input int d, input int base, input string name);
        int n;
        n = 0;
        while (done_count(d) == base && n < 20000) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        check(name, done_count(d) - base, 1);
    endtask

    task automatic wait_done_pulse(input int d, input string name);
        int n;
        logic seen;
        n = 0;
        seen = (d == 0) ? g_mon[0].m_done : g_mon[1].m_done;
        while (seen !== 1'b1 && n < 20000) begin
            @(negedge clk);
            seen = (d == 0) ? g_mon[0].m_done : g_mon[1].m_done;
            n++;
        end
        check(name, seen, 1);
    endtask

    typedef struct {
        logic [7:0] data;
        int         hold;
        int         exp_frames;
        int         exp_done_at;
    } vec_t;

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t vecs[6];
        int   base;

        vecs[0] = '{data: 8'hFF, hold: 1,  exp_frames: 1, exp_done_at: DONE_AT1};
        vecs[1] = '{data: 8'h00, hold: 1,  exp_frames: 1, exp_done_at: DONE_AT1};
        vecs[2] = '{data: 8'hA5, hold: 3,  exp_frames: 1, exp_done_at: DONE_AT1};
        vecs[3] = '{data: 8'h3C, hold: 60, exp_frames: 1, exp_done_at: DONE_AT1};
        vecs[4] = '{data: 8'h81, hold: 1,  exp_frames: 1, exp_done_at: DONE_AT1};
        vecs[5] = '{data: 8'h07, hold: 2,  exp_frames: 1, exp_done_at: DONE_AT1};

        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_txd0",  bus0.txd, 1);
        check("rst_busy0", bus0.tx_busy, 0);
        check("rst_done0", bus0.tx_done, 0);
        check("rst_txd1",  bus1.txd, 1);
        check("rst_busy1", bus1.tx_busy, 0);
        check("rst_done1", bus1.tx_done, 0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("idle_txd0", bus0.txd, 1);
        check("idle_busy1", bus1.tx_busy, 0);

        // Table-driven frames on the DIV=4, two-stop-bit instance.
        foreach (vecs[k]) begin
            base = done_count(1);
            g_mon[1].last_done_at = 0;
            send(1, vecs[k].data, vecs[k].hold);
            wait_done(1, base, "tbl_wait_done");
            repeat (10) @(negedge clk);
            check($sformatf("tbl%0d_frames", k), done_count(1) - base, vecs[k].exp_frames);
            check($sformatf("tbl%0d_done_at", k), g_mon[1].last_done_at, vecs[k].exp_done_at);
            $display("vec %0d data 0x%02h hold %0d done_at %0d", k, vecs[k].data, vecs[k].hold,
                     g_mon[1].last_done_at);
        end

        // A rising edge during the DONE cycle is dropped.
        base = done_count(1);
        send(1, 8'h12, 1);
        wait_done_pulse(1, "drop_done_seen");
        drive(1, 1'b1, 8'h34);
        @(posedge clk); #1;
        drive(1, 1'b0, 8'h34);
        repeat (20) @(negedge clk);
        check("drop_in_done_frames", done_count(1) - base, 1);
        check("drop_in_done_busy", bus1.tx_busy, 0);

        // A rising edge in the cycle after DONE is accepted at once.
        base = done_count(1);
        send(1, 8'h56, 1);
        wait_done_pulse(1, "b2b_done_seen");
        @(posedge clk); #1;
        drive(1, 1'b1, 8'h78);
        exp_q.push_back('{dut: 1, data: 8'h78});
        @(posedge clk); #1;
        drive(1, 1'b0, 8'h78);
        @(negedge clk);
        check("b2b_start_txd", bus1.txd, 0);
        check("b2b_start_busy", bus1.tx_busy, 1);
        wait_done(1, base + 1, "b2b_second_frame");
        $display("back-to-back 0x56 then 0x78 done");

        // Full-rate instance: 0xA5 single pulse.
        base = done_count(0);
        g_mon[0].last_done_at = 0;
        send(0, 8'hA5, 1);
        wait_done(0, base, "a5_frame");
        check("a5_done_at", g_mon[0].last_done_at, DONE_AT0);

        // Level-held request: exactly one frame.
        base = done_count(0);
        send(0, 8'h3C, 20000);
        repeat (20) @(negedge clk);
        check("hold_one_frame", done_count(0) - base, 1);
        $display("held tx_start 20000 cycles: %0d frame(s)", done_count(0) - base);

        // Second rising edge mid-frame is ignored, not queued.
        base = done_count(0);
        send(0, 8'h55, 1);
        repeat (1000) @(posedge clk);
        #1;
        drive(0, 1'b1, 8'hAA);
        @(posedge clk); #1;
        drive(0, 1'b0, 8'hAA);
        wait_done(0, base, "midframe_req_frame");
        repeat (30) @(negedge clk);
        check("midframe_req_not_queued", bus0.tx_busy, 0);
        check("midframe_req_txd_idle", bus0.txd, 1);

        // Reset mid-frame: line released immediately, no tx_done.
        base = done_count(0);
        send(0, 8'h96, 1);
        repeat (2000) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_txd", bus0.txd, 1);
        check("midrst_busy", bus0.tx_busy, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("midrst_no_done", done_count(0) - base, 0);
        send(0, 8'h0F, 1);
        wait_done(0, base, "post_rst_frame");
        $display("reset mid-frame then 0x0F frame done");

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
